axi_burst_ctrl: RTL
===================

AXI_BURST_CTRL -- requirements
Module: axi_burst_ctrl

Interface
REQ-001 The block SHALL have one clock `aclk` and a synchronous, active-high reset `reset`, with all logic on the rising edge of `aclk`.
REQ-002 It SHALL have the following ports (name, direction, width, meaning):
- `aclk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted this cycle.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: burst start address, word-aligned.
- `blen` in 6: beats minus one (1..64 beats).
- `btyp` in 2: burst type. 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `datain` in 32, `din_valid` in 1, `din_ready` out 1: write-data source.
- `dataout` out 32, `dout_valid` out 1: read-data sink; no backpressure.
- `done` out 1: one-cycle pulse at command end.
- `err` out 1: valid with `done`.
- `awvalid` out 1, `awadd` out 32, `awready` in 1: write-address channel.
- `wvalid` out 1, `wdata` out 32, `wlast` out 1, `wready` in 1: write-data channel.
- `bvalid` in 1, `bresp` in 2, `bready` out 1: write-response channel.
- `arvalid` out 1, `aradd` out 32, `aready` in 1: read-address channel.
- `rvalid` in 1, `rdata` in 32, `rlast` in 1, `rready` out 1: read-data channel.
- `bus_blen` out 6, `bus_btyp` out 2, `bsize` out 9: burst attributes of the current command. `bsize` is the constant 4 (bytes per beat).
- `rcount` out 6: beats completed in the current burst.

Function
REQ-003 The FSM SHALL have the states IDLE, WADDR, WDATA, WRESP, RADDR, RDATA and REJECT.
REQ-004 `cmd_ready` SHALL be 1 only in IDLE; on `cmd_valid` & `cmd_ready` the block SHALL latch `cmd_addr`, `blen`, `btyp` and `cmd_wr` into `bus_*` / internal registers.
REQ-005 An accepted command with `btyp`=11, or with `btyp`=WRAP and `blen` not in {1,3,7,15}, SHALL go to REJECT and cause no bus activity.
REQ-006 REJECT SHALL last one cycle, pulse `done`=1 with `err`=1, then return to IDLE.
REQ-007 Any other accepted command SHALL go to WADDR (`cmd_wr`=1) or RADDR (`cmd_wr`=0) on the next cycle.
REQ-008 In WADDR, `awvalid`=1 and `awadd`=latched address SHALL be held stable until `awready`; the handshake cycle SHALL move to WDATA.
REQ-009 In WDATA:
- `wvalid` SHALL equal `din_valid`, `wdata` SHALL equal `datain`, and `din_ready` SHALL equal `wready`.
- `wvalid` SHALL NOT depend on `wready`.
REQ-010 Each `wvalid` & `wready` cycle SHALL increment `rcount`.
REQ-011 `wlast` SHALL be asserted while `rcount`==`bus_blen`; the handshake of that beat SHALL move to WRESP.
REQ-012 In WRESP, `bready`=1; on `bvalid` the block SHALL pulse `done`, set `err`=(`bresp`!=00), and return to IDLE.
REQ-013 In RADDR, `arvalid`=1 and `aradd`=latched address SHALL be held stable until `aready`; the handshake SHALL move to RDATA.
REQ-014 In RDATA, `rready`=1, `dataout`=`rdata` and `dout_valid`=`rvalid`; each `rvalid` beat SHALL increment `rcount`, saturating at 63.
REQ-015 A read burst SHALL end on the `rvalid` & `rlast` beat: pulse `done`, set `err`=(`rcount`!=`bus_blen` at that beat), return to IDLE.
REQ-016 A missing `rlast` after `bus_blen`+1 beats SHALL NOT end the burst; the block SHALL wait for `rlast` and flag `err`.
REQ-017 `rcount` SHALL clear to 0 on command acceptance.
REQ-018 `done` SHALL be asserted in exactly one cycle per accepted command; no new command SHALL be accepted in the `done` cycle.
REQ-019 Valid and ready outputs SHALL be 0 in every state other than those defined above.

Reset
REQ-020 On `reset`=1 at a clock edge:
- state SHALL become IDLE;
- all outputs except the constant `bsize` SHALL be 0;
- latched registers and `rcount` SHALL be 0.
REQ-021 Reset mid-burst SHALL abandon the burst without a `done` pulse; the first command after reset SHALL be accepted normally.

Structure
REQ-022 The state enum, the `btyp` constants (FIXED/INCR/WRAP) and the OKAY response code SHALL live in a shared package `axi_pkg`.
REQ-023 Beat counting and `last` generation SHALL be a sub-module `axi_beat_cnt` (clear, increment, saturate, `is_last` compare), used by both the write and read paths.

Verification
REQ-024 Write INCR, `blen`=3, `awready` delayed 2 cycles: expect 4 `wdata` beats with `wlast` on the 4th only, `bresp`=00, `done`=1, `err`=0.
REQ-025 Write with `din_valid` toggling and `wready` stalls: no beat lost or duplicated, `rcount` ends at 3, `wvalid` constant while `wready`=0.
REQ-026 Read `blen`=7, slave asserts `rlast` on beat 8: expect 8 `dout_valid` pulses, `done`, `err`=0. Then `rlast` on beat 6: expect `done`, `err`=1.
REQ-027 WRAP with `blen`=5: expect REJECT, `done`=1 and `err`=1 one cycle after acceptance, with no `awvalid`/`arvalid` ever asserted.
REQ-028 Reset asserted during WDATA beat 2: next cycle all outputs are 0 and state is IDLE; a following read command completes with `err`=0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI burst definitions: FSM states, burst-type and response codes,
// the latched command payload and the burst legality rule.
package axi_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 6;
   localparam int unsigned SIZE_W = 9;

   localparam logic [1:0] BTYP_FIXED = 2'b00;
   localparam logic [1:0] BTYP_INCR  = 2'b01;
   localparam logic [1:0] BTYP_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   localparam logic [SIZE_W-1:0] BEAT_BYTES = SIZE_W'(4);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WADDR  = 3'd1,
      WDATA  = 3'd2,
      WRESP  = 3'd3,
      RADDR  = 3'd4,
      RDATA  = 3'd5,
      REJECT = 3'd6
   } state_e;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  blen;
      logic [1:0]        btyp;
   } cmd_t;

   // WRAP bursts must be 2, 4, 8 or 16 beats; the reserved type is never legal
   function automatic logic burst_illegal(input logic [1:0] btyp, input logic [LEN_W-1:0] blen);
      logic bad;
      case (btyp)
         BTYP_FIXED, BTYP_INCR: bad = 1'b0;
         BTYP_WRAP: bad = !((blen == LEN_W'(1)) || (blen == LEN_W'(3)) ||
                            (blen == LEN_W'(7)) || (blen == LEN_W'(15)));
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/axi_beat_cnt.sv
// Beat counter shared by the write and read paths: clears on command
// acceptance, counts handshaken beats, saturates at all-ones.
module axi_beat_cnt
   import axi_pkg::*;
(
   input  logic             aclk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   input  logic [LEN_W-1:0] limit,
   output logic [LEN_W-1:0] count,
   output logic             is_last
);

   localparam logic [LEN_W-1:0] CNT_MAX = '1;

   always_ff @(posedge aclk) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + LEN_W'(1);
      end
   end

   assign is_last = (count == limit);

endmodule

// File: rtl/axi_burst_ctrl.sv
// Single-burst AXI master: accepts one command, runs the write or read
// burst on the AXI channels and reports completion with done/err.
module axi_burst_ctrl
   import axi_pkg::*;
(
   input  logic              aclk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  blen,
   input  logic [1:0]        btyp,
   input  logic [DATA_W-1:0] datain,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [DATA_W-1:0] dataout,
   output logic              dout_valid,
   output logic              done,
   output logic              err,
   output logic              awvalid,
   output logic [ADDR_W-1:0] awadd,
   input  logic              awready,
   output logic              wvalid,
   output logic [DATA_W-1:0] wdata,
   output logic              wlast,
   input  logic              wready,
   input  logic              bvalid,
   input  logic [1:0]        bresp,
   output logic              bready,
   output logic              arvalid,
   output logic [ADDR_W-1:0] aradd,
   input  logic              aready,
   input  logic              rvalid,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rlast,
   output logic              rready,
   output logic [LEN_W-1:0]  bus_blen,
   output logic [1:0]        bus_btyp,
   output logic [SIZE_W-1:0] bsize,
   output logic [LEN_W-1:0]  rcount
);

   state_e           state, nstate;
   cmd_t             cmd_q;
   logic             rdy_q;
   logic             ovr_q;
   logic             accept;
   logic             wbeat, rbeat, beat_inc;
   logic             is_last;
   logic [LEN_W-1:0] cnt;

   assign accept = cmd_valid & rdy_q;
   assign wbeat  = (state == WDATA) & din_valid & wready;
   assign rbeat  = (state == RDATA) & rvalid;
   assign beat_inc = cmd_q.wr ? wbeat : rbeat;

   // state register
   always_ff @(posedge aclk) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   // next-state logic
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (accept) nstate = burst_illegal(btyp, blen) ? REJECT
                                                                : (cmd_wr ? WADDR : RADDR);
         REJECT:  nstate = IDLE;
         WADDR:   if (awready) nstate = WDATA;
         WDATA:   if (wbeat && is_last) nstate = WRESP;
         WRESP:   if (bvalid) nstate = IDLE;
         RADDR:   if (aready) nstate = RDATA;
         RDATA:   if (rvalid && rlast) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // command latch, ready flag and read-overrun flag; ready stays low for a cycle after reset
   always_ff @(posedge aclk) begin
      if (reset) begin
         cmd_q <= '0;
         rdy_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         rdy_q <= (nstate == IDLE);
         if (accept) begin
            cmd_q.wr   <= cmd_wr;
            cmd_q.addr <= cmd_addr;
            cmd_q.blen <= blen;
            cmd_q.btyp <= btyp;
            ovr_q      <= 1'b0;
         end else if (rbeat && !rlast && is_last) begin
            ovr_q <= 1'b1;
         end
      end
   end

   axi_beat_cnt u_beat_cnt (
      .aclk    (aclk),
      .reset   (reset),
      .clr     (accept),
      .inc     (beat_inc),
      .limit   (cmd_q.blen),
      .count   (cnt),
      .is_last (is_last)
   );

   // channel outputs decoded from the current state
   always_comb begin
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      wdata      = '0;
      wlast      = 1'b0;
      din_ready  = 1'b0;
      bready     = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      dataout    = '0;
      dout_valid = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      case (state)
         REJECT: begin
            done = 1'b1;
            err  = 1'b1;
         end
         WADDR: awvalid = 1'b1;
         WDATA: begin
            wvalid    = din_valid;
            wdata     = datain;
            din_ready = wready;
            wlast     = is_last;
         end
         WRESP: begin
            bready = 1'b1;
            done   = bvalid;
            err    = bvalid & (bresp != RESP_OKAY);
         end
         RADDR: arvalid = 1'b1;
         RDATA: begin
            rready     = 1'b1;
            dataout    = rdata;
            dout_valid = rvalid;
            done       = rvalid & rlast;
            err        = rvalid & rlast & ((cnt != cmd_q.blen) | ovr_q);
         end
         default: ;
      endcase
   end

   assign cmd_ready = rdy_q;
   assign awadd     = cmd_q.addr;
   assign aradd     = cmd_q.addr;
   assign bus_blen  = cmd_q.blen;
   assign bus_btyp  = cmd_q.btyp;
   assign bsize     = BEAT_BYTES;
   assign rcount    = cnt;

endmodule
